booth_mult_unit: RTL and testbench



---
 rtl/mult_pkg.sv | 19 +
 rtl/booth_mult_unit_if.sv | 34 +++
 rtl/booth_step.sv | 42 ++++
 rtl/booth_mult_unit.sv | 126 ++++++++++++
 tb/tb_booth_mult_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiply unit.
//   MULT_WIDTH : default operand width (MIPS word)
//   state_t    : control states of the iterative multiplier
//   BOOTH_*    : encodings of the {Q[0], q_1} pair examined each step
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Pair 2'b11 behaves exactly like BOOTH_NOP (inside a run of ones).
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : mult_pkg

// File: rtl/booth_mult_unit_if.sv
// Request/response bundle between the execute stage and the multiply unit.
//   start     : one-cycle request, honoured only while idle
//   signed_op : 1 = MULT, 0 = MULTU, latched with start
//   a, b      : multiplicand / multiplier, latched with start
//   busy      : operation in progress
//   done      : one-cycle pulse, hi/lo hold a new result
//   hi, lo    : upper / lower halves of the product
// master = requester (execute stage), slave = multiply unit.
interface booth_mult_unit_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );

endinterface : booth_mult_unit_if

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc_in, q_in, q_1_in : current {A, Q, q_1}
//   m                    : extended multiplicand
//   acc_out, q_out, q_1_out : {A, Q, q_1} after add/sub and arithmetic shift
// All quantities are WIDTH+1 bits; carry out of the add is discarded.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0] acc_in,
  input  logic [WIDTH:0] q_in,
  input  logic           q_1_in,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] acc_out,
  output logic [WIDTH:0] q_out,
  output logic           q_1_out
);

  logic [1:0]     pair;
  logic [WIDTH:0] sum;

  assign pair = {q_in[0], q_1_in};

  // NOTE: combinational blocks assign every output a default first so no
  // path through the case leaves a value held, which would infer a latch.
  always_comb begin
    sum = acc_in;
    unique case (pair)
      BOOTH_ADD: sum = acc_in + m;
      BOOTH_SUB: sum = acc_in - m;
      default:   sum = acc_in;
    endcase
  end

  // Arithmetic right shift of the concatenation {sum, Q, q_1}: the sign
  // bit of sum is replicated, its LSB moves into Q, Q's LSB into q_1.
  assign acc_out = {sum[WIDTH], sum[WIDTH:1]};
  assign q_out   = {sum[0], q_in[WIDTH:1]};
  assign q_1_out = q_in[0];

endmodule : booth_step

// File: rtl/booth_mult_unit.sv
// Iterative radix-2 Booth multiplier for MIPS MULT/MULTU.
//   clock : system clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : booth_mult_unit_if.slave (start/signed_op/a/b in,
//           busy/done/hi/lo out)
// Operands are extended to WIDTH+1 bits so signed and unsigned operations
// share the same signed Booth datapath; WIDTH+1 steps give the full
// product, whose low 2*WIDTH bits are the architectural HI:LO result.
module booth_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clock,
  input  logic               rst,
  booth_mult_unit_if.slave   bus
);

  localparam int STEPS    = WIDTH + 1;
  localparam int CNT_W    = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t state, next_state;

  logic [WIDTH:0]     acc_q, mq_q, m_q;
  logic               q_1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH:0]     step_acc, step_q;
  logic               step_q_1;

  logic               load, do_step, finish;
  logic [WIDTH:0]     ext_a, ext_b;

  // Sign- or zero-extend according to the operation type.
  assign ext_a = {bus.signed_op & bus.a[WIDTH-1], bus.a};
  assign ext_b = {bus.signed_op & bus.b[WIDTH-1], bus.b};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .q_in    (mq_q),
    .q_1_in  (q_1_q),
    .m       (m_q),
    .acc_out (step_acc),
    .q_out   (step_q),
    .q_1_out (step_q_1)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    do_step    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        // start arriving in the done cycle lands here, so back-to-back
        // requests are accepted without a bubble.
        if (bus.start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        // start is not examined here: requests while busy are dropped.
        do_step = 1'b1;
        if (cnt_q == LAST_STEP) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      acc_q  <= '0;
      mq_q   <= '0;
      m_q    <= '0;
      q_1_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= finish;
      if (load) begin
        m_q    <= ext_a;
        mq_q   <= ext_b;
        acc_q  <= '0;
        q_1_q  <= 1'b0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
      if (do_step) begin
        acc_q <= step_acc;
        mq_q  <= step_q;
        q_1_q <= step_q_1;
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        // Low 2*WIDTH bits of the shifted {A, Q}; the top two bits are
        // redundant sign bits of the (WIDTH+1)x(WIDTH+1) product.
        hi_q   <= {step_acc[WIDTH-2:0], step_q[WIDTH]};
        lo_q   <= step_q[WIDTH-1:0];
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule : booth_mult_unit

// File: tb/tb_booth_mult_unit.sv
// Self-checking bench for booth_mult_unit: directed cases plus random
// operands compared against a plain-arithmetic 64-bit product model.
module tb_booth_mult_unit;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  int checks = 0;
  int errors = 0;

  booth_mult_unit_if #(.WIDTH(W)) bus ();

  booth_mult_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic s,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
    if (s) return longint'($signed(x)) * longint'($signed(y));
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Present a request for one edge, then scramble the inputs so the bench
  // notices any result that depends on post-start operand values.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.a         = x;
    bus.b         = y;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.a         = $urandom;
    bus.b         = $urandom;
  endtask

  // Count edges until done is seen (sampled #1 after each edge); busy
  // must stay high on every edge before that.
  task automatic wait_done(input string tag, output int n);
    bit busy_dropped = 0;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (!bus.done && !bus.busy) busy_dropped = 1;
    end while (!bus.done && n < 80);
    check({tag, "_busy_held"}, 64'(busy_dropped), 64'd0);
    check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic s,
                        input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [63:0] exp;
    exp = ref_prod(s, x, y);
    issue(s, x, y);
    check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    wait_done(tag, n);
    check({tag, "_latency"}, 64'(n), 64'(LATENCY));
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
    @(posedge clock);
    #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_hilo_hold"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    int n;
    bit seen;

    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {28'd0, bus.busy, bus.done, 2'b00, bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;

    // Directed products.
    run_op("s_7x6",      1'b1, 32'd7,        32'd6);
    check("s_7x6_lo",    64'(bus.lo), 64'h2A);
    run_op("s_m3x5",     1'b1, 32'hFFFFFFFD, 32'd5);
    check("s_m3x5_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op("s_m1xm1",    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("s_m1xm1_hilo", {bus.hi, bus.lo}, 64'h00000000_00000001);
    run_op("u_max",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("u_max_hilo",  {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    run_op("s_min",      1'b1, 32'h80000000, 32'h80000000);
    check("s_min_hilo",  {bus.hi, bus.lo}, 64'h40000000_00000000);
    run_op("u_msb_x2",   1'b0, 32'h80000000, 32'd2);
    check("u_msb_x2_hilo", {bus.hi, bus.lo}, 64'h00000001_00000000);

    // Start while busy is dropped; start in the done cycle is taken.
    issue(1'b1, 32'd7, 32'd6);
    repeat (4) @(posedge clock);
    @(negedge clock);
    bus.start = 1'b1;
    bus.signed_op = 1'b1;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'hFFFFFFFF;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_done("ignore", n);
    check("ignore_latency", 64'(n + 5), 64'(LATENCY));
    check("ignore_hilo", {bus.hi, bus.lo}, 64'd42);
    issue(1'b0, 32'd3, 32'd4);
    check("b2b_done_clear", 64'(bus.done), 64'd0);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done("b2b", n);
    check("b2b_latency", 64'(n), 64'(LATENCY));
    check("b2b_hilo", {bus.hi, bus.lo}, 64'h0C);

    // Reset mid-operation.
    issue(1'b1, 32'd7, 32'd6);
    repeat (9) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    check("abort_state", {28'd0, bus.busy, bus.done, 2'b00, bus.hi, bus.lo}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) seen = 1;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    run_op("after_abort", 1'b1, 32'd2, 32'd3);
    check("after_abort_lo", 64'(bus.lo), 64'd6);

    // rst wins over a simultaneous start.
    @(negedge clock);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_over_start", 64'(bus.busy), 64'd0);

    // Random operands of both kinds.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      logic s;
      x = $urandom;
      y = $urandom;
      s = 1'($urandom);
      if (i % 6 == 0) x = 32'h80000000;
      if (i % 8 == 1) y = 32'hFFFFFFFF;
      run_op($sformatf("rand%0d", i), s, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_booth_mult_unit
